// File: rtl/mc_cu_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit and its decoder.
// Pure declarations: no logic, no latency, no flow control.
package mc_cu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JR     = 2'b10;
  localparam logic [1:0] PCS_JUMP   = 2'b11;

  // One-hot instruction flags; all-zero means the instruction is illegal.
  typedef struct packed {
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw;
    logic i_beq, i_bne, i_j, i_jal;
  } inst_t;

  typedef struct packed {
    logic       pcwrite, irwrite, iord, wmem, wreg, regrt, m2reg, jal;
    logic       shift, aluimm, sext, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic       ill;
  } ctl_t;

endpackage

// File: rtl/mc_cu_if.sv
// Control-unit bundle: IR fields and memory handshake in, datapath controls out.
// Purely wires; mem_ready is the only backpressure and is consumed by the control unit.
interface mc_cu_if;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        z;
  logic        mem_ready;
  logic        pcwrite, irwrite, iord, wmem, wreg, regrt, m2reg, jal;
  logic        shift, aluimm, sext, alusrca;
  logic [1:0]  alusrcb;
  logic [3:0]  aluc;
  logic [1:0]  pcsource;
  logic        ill;
  logic [2:0]  state;
  logic [31:0] icount;

  modport master (
    input  op, func, z, mem_ready,
    output pcwrite, irwrite, iord, wmem, wreg, regrt, m2reg, jal,
    output shift, aluimm, sext, alusrca, alusrcb, aluc, pcsource, ill, state, icount
  );

  modport slave (
    output op, func, z, mem_ready,
    input  pcwrite, irwrite, iord, wmem, wreg, regrt, m2reg, jal,
    input  shift, aluimm, sext, alusrca, alusrcb, aluc, pcsource, ill, state, icount
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational MIPS decoder: one-hot instruction flags plus static EXE/WB controls.
// Zero latency; no flow control.
module mc_decode
  import mc_cu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output inst_t      inst,
  output logic       regrt,
  output logic       aluimm,
  output logic       sext,
  output logic       shift,
  output logic [3:0] aluc
);

  always_comb begin
    inst   = '0;
    regrt  = 1'b0;
    aluimm = 1'b0;
    sext   = 1'b0;
    shift  = 1'b0;
    aluc   = ALUC_ADD;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD: inst.i_add = 1'b1;
          FN_SUB: begin inst.i_sub = 1'b1; aluc = ALUC_SUB; end
          FN_AND: begin inst.i_and = 1'b1; aluc = ALUC_AND; end
          FN_OR:  begin inst.i_or  = 1'b1; aluc = ALUC_OR;  end
          FN_XOR: begin inst.i_xor = 1'b1; aluc = ALUC_XOR; end
          FN_SLL: begin inst.i_sll = 1'b1; shift = 1'b1; aluc = ALUC_SLL; end
          FN_SRL: begin inst.i_srl = 1'b1; shift = 1'b1; aluc = ALUC_SRL; end
          FN_SRA: begin inst.i_sra = 1'b1; shift = 1'b1; aluc = ALUC_SRA; end
          FN_JR:  inst.i_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin inst.i_addi = 1'b1; regrt = 1'b1; aluimm = 1'b1; sext = 1'b1; end
      OP_ANDI: begin inst.i_andi = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = ALUC_AND; end
      OP_ORI:  begin inst.i_ori  = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = ALUC_OR;  end
      OP_XORI: begin inst.i_xori = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = ALUC_XOR; end
      OP_LUI:  begin inst.i_lui  = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = ALUC_LUI; end
      OP_LW:   begin inst.i_lw   = 1'b1; regrt = 1'b1; aluimm = 1'b1; sext = 1'b1; end
      OP_SW:   begin inst.i_sw   = 1'b1; aluimm = 1'b1; sext = 1'b1; end
      OP_BEQ:  begin inst.i_beq  = 1'b1; sext = 1'b1; aluc = ALUC_SUB; end
      OP_BNE:  begin inst.i_bne  = 1'b1; sext = 1'b1; aluc = ALUC_SUB; end
      OP_J:    inst.i_j   = 1'b1;
      OP_JAL:  inst.i_jal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_cu.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB FSM, combinational controls, retire counter.
// Latency 2-5 cycles per instruction; mem_ready low holds IF or MEM one cycle per wait.
module mc_cu
  import mc_cu_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  mc_cu_if.master  cu
);

  state_e      state_q, state_d;
  logic [31:0] icount_q;
  inst_t       inst;
  logic        dec_regrt, dec_aluimm, dec_sext, dec_shift;
  logic [3:0]  dec_aluc;
  logic        legal, retire;
  ctl_t        ctl;

  mc_decode u_decode (
    .op     (cu.op),
    .func   (cu.func),
    .inst   (inst),
    .regrt  (dec_regrt),
    .aluimm (dec_aluimm),
    .sext   (dec_sext),
    .shift  (dec_shift),
    .aluc   (dec_aluc)
  );

  assign legal = |inst;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IF;
      icount_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) icount_q <= icount_q + 32'd1;
    end
  end

  // retire marks every legal instruction's final cycle, i.e. the edge back to IF.
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    retire  = 1'b0;
    case (state_q)
      S_IF: begin
        ctl.alusrcb = SRCB_FOUR;
        if (cu.mem_ready) begin
          ctl.pcwrite = 1'b1;
          ctl.irwrite = 1'b1;
          state_d     = S_ID;
        end
      end
      S_ID: begin
        ctl.alusrcb = SRCB_BRANCH;
        if (inst.i_j || inst.i_jal) begin
          ctl.pcwrite  = 1'b1;
          ctl.pcsource = PCS_JUMP;
          ctl.wreg     = inst.i_jal;
          ctl.jal      = inst.i_jal;
          retire       = 1'b1;
          state_d      = S_IF;
        end else if (inst.i_jr) begin
          ctl.pcwrite  = 1'b1;
          ctl.pcsource = PCS_JR;
          retire       = 1'b1;
          state_d      = S_IF;
        end else if (!legal) begin
          ctl.ill = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        ctl.alusrca = 1'b1;
        ctl.aluimm  = dec_aluimm;
        ctl.shift   = dec_shift;
        ctl.sext    = dec_sext;
        ctl.aluc    = dec_aluc;
        ctl.alusrcb = dec_aluimm ? SRCB_IMM : SRCB_REG;
        if (inst.i_beq || inst.i_bne) begin
          ctl.pcsource = PCS_BRANCH;
          ctl.pcwrite  = (inst.i_beq & cu.z) | (inst.i_bne & ~cu.z);
          retire       = 1'b1;
          state_d      = S_IF;
        end else if (inst.i_lw || inst.i_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ctl.iord = 1'b1;
        ctl.wmem = inst.i_sw;
        if (cu.mem_ready) begin
          retire  = inst.i_sw;
          state_d = inst.i_sw ? S_IF : S_WB;
        end
      end
      S_WB: begin
        ctl.wreg  = 1'b1;
        ctl.m2reg = inst.i_lw;
        ctl.regrt = dec_regrt;
        retire    = 1'b1;
        state_d   = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Write enables and ill are masked combinationally so reset silences them in the same cycle.
  assign cu.pcwrite  = ctl.pcwrite & ~reset;
  assign cu.irwrite  = ctl.irwrite & ~reset;
  assign cu.wmem     = ctl.wmem    & ~reset;
  assign cu.wreg     = ctl.wreg    & ~reset;
  assign cu.ill      = ctl.ill     & ~reset;
  assign cu.iord     = ctl.iord;
  assign cu.regrt    = ctl.regrt;
  assign cu.m2reg    = ctl.m2reg;
  assign cu.jal      = ctl.jal;
  assign cu.shift    = ctl.shift;
  assign cu.aluimm   = ctl.aluimm;
  assign cu.sext     = ctl.sext;
  assign cu.alusrca  = ctl.alusrca;
  assign cu.alusrcb  = ctl.alusrcb;
  assign cu.aluc     = ctl.aluc;
  assign cu.pcsource = ctl.pcsource;
  assign cu.state    = state_q;
  assign cu.icount   = icount_q;

endmodule

// File: tb/tb_mc_cu.sv
// Randomized instruction stream against a per-instruction cycle-script model of mc_cu,
// plus directed scenarios pinned with hand-computed literals.
module tb_mc_cu;
  import mc_cu_pkg::*;

  logic clock = 1'b0;
  logic reset;
  mc_cu_if bus();

  mc_cu dut (.clock(clock), .reset(reset), .cu(bus));

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pcwrite, irwrite, iord, wmem, wreg, regrt, m2reg, jal;
    logic       shift, aluimm, sext, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic       ill;
    logic [2:0] state;
  } exp_t;

  typedef struct { logic mr; exp_t e; } step_t;

  typedef enum { C_ALU, C_SHIFT, C_ALUI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR } cls_e;
  typedef struct { logic [5:0] op; logic [5:0] fn; cls_e cls; logic [3:0] aluc; logic sx; } ins_t;

  ins_t        itab[20];
  step_t       script[$];
  exp_t        cur;
  logic        chk_en = 1'b0;
  logic [31:0] exp_icount = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  task automatic init_tab();
    itab[0]  = '{6'h00, 6'h20, C_ALU,   4'b0000, 1'b0};
    itab[1]  = '{6'h00, 6'h22, C_ALU,   4'b0100, 1'b0};
    itab[2]  = '{6'h00, 6'h24, C_ALU,   4'b0001, 1'b0};
    itab[3]  = '{6'h00, 6'h25, C_ALU,   4'b0101, 1'b0};
    itab[4]  = '{6'h00, 6'h26, C_ALU,   4'b0010, 1'b0};
    itab[5]  = '{6'h00, 6'h00, C_SHIFT, 4'b0011, 1'b0};
    itab[6]  = '{6'h00, 6'h02, C_SHIFT, 4'b0111, 1'b0};
    itab[7]  = '{6'h00, 6'h03, C_SHIFT, 4'b1111, 1'b0};
    itab[8]  = '{6'h00, 6'h08, C_JR,    4'b0000, 1'b0};
    itab[9]  = '{6'h08, 6'h00, C_ALUI,  4'b0000, 1'b1};
    itab[10] = '{6'h0c, 6'h00, C_ALUI,  4'b0001, 1'b0};
    itab[11] = '{6'h0d, 6'h00, C_ALUI,  4'b0101, 1'b0};
    itab[12] = '{6'h0e, 6'h00, C_ALUI,  4'b0010, 1'b0};
    itab[13] = '{6'h0f, 6'h00, C_ALUI,  4'b0110, 1'b0};
    itab[14] = '{6'h23, 6'h00, C_LW,    4'b0000, 1'b1};
    itab[15] = '{6'h2b, 6'h00, C_SW,    4'b0000, 1'b1};
    itab[16] = '{6'h04, 6'h00, C_BEQ,   4'b0100, 1'b1};
    itab[17] = '{6'h05, 6'h00, C_BNE,   4'b0100, 1'b1};
    itab[18] = '{6'h02, 6'h00, C_J,     4'b0000, 1'b0};
    itab[19] = '{6'h03, 6'h00, C_JAL,   4'b0000, 1'b0};
  endtask

  function automatic int find(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < 20; i++)
      if (itab[i].op == op && (op != 6'h00 || itab[i].fn == fn)) return i;
    return -1;
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom % 2);
  endfunction

  task automatic push(input logic mr, input exp_t e);
    step_t s;
    s.mr = mr;
    s.e  = e;
    script.push_back(s);
  endtask

  // Expected outputs for every cycle of one instruction, from fetch to its last cycle.
  task automatic build(input int idx, input logic z, input int wif, input int wm);
    exp_t e;
    cls_e c;
    script.delete();
    for (int i = 0; i <= wif; i++) begin
      e = '0; e.state = 3'd0; e.alusrcb = 2'b01;
      e.pcwrite = (i == wif); e.irwrite = (i == wif);
      push(i == wif, e);
    end
    e = '0; e.state = 3'd1; e.alusrcb = 2'b11;
    if (idx < 0) begin
      e.ill = 1'b1;
      push(rnd_bit(), e);
      return;
    end
    c = itab[idx].cls;
    if (c == C_J || c == C_JAL) begin e.pcwrite = 1'b1; e.pcsource = 2'b11; end
    if (c == C_JAL) begin e.wreg = 1'b1; e.jal = 1'b1; end
    if (c == C_JR) begin e.pcwrite = 1'b1; e.pcsource = 2'b10; end
    push(rnd_bit(), e);
    if (c == C_J || c == C_JAL || c == C_JR) return;
    e = '0; e.state = 3'd2; e.alusrca = 1'b1;
    e.aluc = itab[idx].aluc; e.sext = itab[idx].sx; e.shift = (c == C_SHIFT);
    e.aluimm = (c == C_ALUI || c == C_LW || c == C_SW);
    e.alusrcb = e.aluimm ? 2'b10 : 2'b00;
    if (c == C_BEQ || c == C_BNE) begin
      e.pcsource = 2'b01;
      e.pcwrite  = (c == C_BEQ) ? z : ~z;
      push(rnd_bit(), e);
      return;
    end
    push(rnd_bit(), e);
    if (c == C_LW || c == C_SW) begin
      for (int i = 0; i <= wm; i++) begin
        e = '0; e.state = 3'd3; e.iord = 1'b1; e.wmem = (c == C_SW);
        push(i == wm, e);
      end
      if (c == C_SW) return;
    end
    e = '0; e.state = 3'd4; e.wreg = 1'b1; e.m2reg = (c == C_LW);
    e.regrt = (c == C_ALUI || c == C_LW);
    push(rnd_bit(), e);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int limit);
    for (int i = 0; i < script.size() && i < limit; i++) begin
      @(negedge clock);
      bus.op = op; bus.func = fn; bus.z = z;
      bus.mem_ready = script[i].mr;
      cur = script[i].e;
      chk_en = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int wif, input int wm);
    int idx;
    idx = find(op, fn);
    build(idx, z, wif, wm);
    run(op, fn, z, 1000);
    if (idx >= 0) exp_icount = exp_icount + 32'd1;
  endtask

  always @(negedge clock) begin
    exp_t got;
    #2;
    if (chk_en) begin
      got.pcwrite = bus.pcwrite; got.irwrite = bus.irwrite; got.iord = bus.iord;
      got.wmem = bus.wmem; got.wreg = bus.wreg; got.regrt = bus.regrt;
      got.m2reg = bus.m2reg; got.jal = bus.jal; got.shift = bus.shift;
      got.aluimm = bus.aluimm; got.sext = bus.sext; got.alusrca = bus.alusrca;
      got.alusrcb = bus.alusrcb; got.aluc = bus.aluc; got.pcsource = bus.pcsource;
      got.ill = bus.ill; got.state = bus.state;
      chk("outputs", 64'(got), 64'(cur));
      chk("icount", 64'(bus.icount), 64'(exp_icount));
    end
  end

  task automatic chk_quiet(input string name);
    chk(name, 64'({bus.pcwrite, bus.irwrite, bus.wmem, bus.wreg, bus.ill}), 64'd0);
  endtask

  initial begin
    logic [5:0] op, fn;
    int idx;
    init_tab();
    reset = 1'b0;
    bus.op = 6'h00; bus.func = 6'h20; bus.z = 1'b0; bus.mem_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("reset_state", 64'(bus.state), 64'd0);
    chk("reset_icount", 64'(bus.icount), 64'd0);
    chk_quiet("reset_enables");
    @(negedge clock); #2 chk_quiet("reset_hold_enables");
    @(negedge clock);
    bus.mem_ready = 1'b0;
    reset = 1'b0;

    // add: IF,ID,EXE,WB
    build(0, 1'b0, 0, 0);
    chk("add_len", 64'(script.size()), 64'd4);
    chk("add_wb", 64'({script[3].e.wreg, script[3].e.regrt, script[3].e.state}), 64'b1_0_100);
    exec(6'h00, 6'h20, 1'b0, 0, 0);
    chk("add_icount", 64'(bus.icount), 64'd1);

    // lw with two memory wait cycles
    build(14, 1'b0, 0, 2);
    chk("lw_len", 64'(script.size()), 64'd7);
    chk("lw_wb", 64'({script[6].e.m2reg, script[6].e.wreg, script[6].e.regrt}), 64'b111);
    exec(6'h23, 6'h00, 1'b0, 0, 2);
    chk("lw_icount", 64'(bus.icount), 64'd2);

    // beq taken and not taken
    build(16, 1'b1, 0, 0);
    chk("beq_len", 64'(script.size()), 64'd3);
    chk("beq_t_exe", 64'({script[2].e.pcwrite, script[2].e.pcsource}), 64'b1_01);
    exec(6'h04, 6'h00, 1'b1, 0, 0);
    build(16, 1'b0, 0, 0);
    chk("beq_nt_exe", 64'(script[2].e.pcwrite), 64'd0);
    exec(6'h04, 6'h00, 1'b0, 0, 0);
    chk("beq_icount", 64'(bus.icount), 64'd4);

    // jal
    build(19, 1'b0, 0, 0);
    chk("jal_len", 64'(script.size()), 64'd2);
    chk("jal_id", 64'({script[1].e.pcwrite, script[1].e.wreg, script[1].e.jal,
                       script[1].e.pcsource}), 64'b111_11);
    exec(6'h03, 6'h00, 1'b0, 0, 0);
    chk("jal_icount", 64'(bus.icount), 64'd5);

    // illegal opcode
    build(find(6'h3f, 6'h00), 1'b0, 0, 0);
    chk("ill_id", 64'({script[1].e.ill, script[1].e.state}), 64'b1_001);
    exec(6'h3f, 6'h00, 1'b0, 0, 0);
    chk("ill_icount", 64'(bus.icount), 64'd5);

    // sw interrupted by reset while waiting in MEM
    build(15, 1'b0, 0, 3);
    run(6'h2b, 6'h00, 1'b0, 4);
    chk_en = 1'b0;
    chk("sw_wmem_before", 64'({bus.wmem, bus.state}), 64'b1_011);
    reset = 1'b1;
    #1;
    chk("sw_rst_wmem", 64'(bus.wmem), 64'd0);
    chk("sw_rst_state", 64'(bus.state), 64'd0);
    chk("sw_rst_icount", 64'(bus.icount), 64'd0);
    exp_icount = '0;
    bus.mem_ready = 1'b1;
    @(negedge clock); #2 chk_quiet("sw_rst_hold");
    @(negedge clock);
    bus.mem_ready = 1'b0;
    reset = 1'b0;

    // Random stream
    for (int n = 0; n < 300; n++) begin
      if (rnd_bit()) begin
        idx = int'($urandom % 20);
        op  = itab[idx].op;
        fn  = (op == 6'h00) ? itab[idx].fn : 6'($urandom);
      end else begin
        op = ($urandom % 4 == 0) ? 6'h00 : 6'($urandom);
        fn = 6'($urandom);
      end
      exec(op, fn, rnd_bit(), int'($urandom % 4), int'($urandom % 4));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_cu.md
MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 mc_cu SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port list, clock and reset first:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  instruction opcode field, taken from the IR
- func  in  6  function field, taken from the IR
- z  in  1  ALU zero flag
- mem_ready  in  1  memory completion handshake
- pcwrite  out  1  PC load enable
- irwrite  out  1  IR load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALU output register
- wmem  out  1  memory write enable
- wreg  out  1  register-file write enable
- regrt  out  1  destination select: 1 = rt, 0 = rd
- m2reg  out  1  writeback select: 1 = memory data
- jal  out  1  write PC+4 to r31
- shift  out  1  ALU A input = sa
- aluimm  out  1  ALU B input = immediate
- sext  out  1  sign-extend immediate
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 reg, 01 constant 4, 10 immediate, 11 sext immediate << 2
- aluc  out  4  ALU operation
- pcsource  out  2  PC source: 00 ALU result, 01 branch target, 10 rs (jr), 11 jump target
- ill  out  1  one-cycle illegal-instruction pulse
- state  out  3  current FSM state, for debug
- icount  out  32  count of retired instructions

Function
REQ-003 The FSM SHALL have five states: IF=0, ID=1, EXE=2, MEM=3, WB=4; encodings 5-7 SHALL go to IF on the next edge.
REQ-004 Supported instructions: add sub and or xor sll srl sra jr addi andi ori xori lw sw beq bne lui j jal (MIPS encodings); anything else is illegal.
REQ-005 IF: iord=0, alusrca=0, alusrcb=01, pcsource=00, aluc=0000; while mem_ready=0 the FSM SHALL hold IF; on mem_ready=1, pcwrite=irwrite=1 for that cycle and next state is ID.
REQ-006 ID: alusrca=0, alusrcb=11, aluc=0000 (branch target latched into ALU out).
- j: pcwrite=1, pcsource=11, then IF.
- jal: pcwrite=1, pcsource=11, wreg=jal=1, then IF.
- jr: pcwrite=1, pcsource=10, then IF.
- illegal: ill=1, no write enables, then IF.
- all others: EXE.
REQ-007 EXE: alusrca=1; alusrcb and the aluimm, shift and sext controls come from the decoded instruction.
- beq/bne: aluc=0100; pcwrite=1 with pcsource=01 iff (beq&z)|(bne&~z); then IF.
- lw/sw: then MEM.
- others: then WB.
REQ-008 aluc codes SHALL be:
- add/addi/lw/sw 0000
- and/andi 0001
- xor/xori 0010
- sll 0011
- sub/beq/bne 0100
- or/ori 0101
- lui 0110
- srl 0111
- sra 1111
REQ-009 MEM: iord=1; sw asserts wmem=1 until mem_ready=1, then IF; lw holds until mem_ready=1, then WB; state SHALL hold while mem_ready=0.
REQ-010 WB: wreg=1; m2reg=1 for lw; regrt=1 for I-type; then IF.
REQ-011 All outputs SHALL be combinational from state, op, func, z and mem_ready; every write enable (pcwrite, irwrite, wmem, wreg) SHALL be 0 outside the cases above.
REQ-012 icount SHALL increment by 1 (wrapping at 2^32-1 to 0) on every transition to IF from a legal instruction; illegal instructions SHALL NOT count.
REQ-013 Latency in cycles, with zero memory wait: j/jal/jr 2, branch 3, ALU 4, sw 4, lw 5; each mem_ready=0 cycle adds one.

Reset
REQ-014 reset=1 SHALL immediately force state=IF and icount=0.
REQ-015 While reset=1, pcwrite, irwrite, wmem, wreg and ill SHALL be 0 regardless of mem_ready.
REQ-016 A reset asserted mid-instruction SHALL abandon that instruction with no further writes and no icount increment.

Structure
REQ-017 Package mc_cu_pkg SHALL hold the state enum, aluc constants, opcode/func constants and alusrcb/pcsource encodings.
REQ-018 Instruction decode SHALL be one combinational sub-module, mc_decode, producing one-hot instruction flags plus regrt, aluimm, sext, shift and aluc.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- add, mem_ready=1 throughout -> states IF,ID,EXE,WB,IF; wreg=1 only in WB with regrt=0; icount 0 -> 1.
- lw with mem_ready low 2 cycles in MEM -> 7 cycles total; m2reg=wreg=1 in WB; iord=1 throughout MEM.
- beq with z=1, then with z=0 -> pcwrite=1 with pcsource=01 in EXE only when z=1; both take 3 cycles.
- jal -> in ID: pcwrite=wreg=jal=1, pcsource=11; returns to IF after 2 cycles.
- op=111111 -> ill=1 for one cycle in ID; no write enables; icount unchanged.
- reset asserted during MEM of sw -> wmem drops to 0 in the same cycle; state=IF; icount=0.
